// File: rtl/m16_pkg.sv
// Shared types and default geometry for the M16 imitator frame path.
package m16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } m16_state_e;

  localparam int unsigned M16_FRAME_WORDS = 2048;
  localparam int unsigned M16_GROUPS      = 32;
  localparam int unsigned M16_PTR_W       = 11;
  localparam int unsigned M16_GRP_W       = 5;

endpackage

// File: rtl/m16_word_timer.sv
// Word-period down-counter: tick is high for one clock every WORD_DIV clocks while run=1.
module m16_word_timer #(
  parameter int unsigned WORD_DIV = 96
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic tick
);

  localparam int unsigned     CW     = (WORD_DIV < 2) ? 1 : $clog2(WORD_DIV);
  localparam logic [CW-1:0]   RELOAD = CW'(WORD_DIV - 1);

  generate
    if (WORD_DIV < 2) begin : g_bad_div
      $error("m16_word_timer: WORD_DIV must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (run) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
    end
  end

  assign tick = run && (cnt == '0);

endmodule

// File: rtl/m16_frame_sequencer.sv
// Read-side timing master: word strobe, word address and frame-group index for the frame filler.
module m16_frame_sequencer
  import m16_pkg::*;
#(
  parameter int unsigned WORD_DIV        = 96,
  parameter int unsigned WORDS_PER_FRAME = M16_FRAME_WORDS,
  parameter int unsigned GROUPS          = M16_GROUPS,
  parameter int unsigned PTR_W           = M16_PTR_W,
  parameter int unsigned GRP_W           = M16_GRP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             bufGetWord,
  output logic [PTR_W-1:0] bufRdPointer,
  output logic [GRP_W-1:0] cntGrp,
  output logic             frameStart,
  output logic             groupStart,
  output logic             running
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS_PER_FRAME - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  m16_state_e state, state_d;
  logic       tick;
  logic       load;
  logic       last_done;

  m16_word_timer #(
    .WORD_DIV(WORD_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .run  (state != IDLE),
    .tick (tick)
  );

  // Last word of the frame is being strobed; the edge ending it may stop the sequencer.
  assign last_done = bufGetWord && (bufRdPointer == PTR_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_d = ARM;
          load    = 1'b1;
        end
      end
      ARM:     if (tick) state_d = enable ? RUN : DRAIN;
      RUN: begin
        if (!enable) state_d = last_done ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable)         state_d = RUN;
        else if (last_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address advances on the edge that ends a strobe, so it is stable throughout the strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bufGetWord   <= 1'b0;
      frameStart   <= 1'b0;
      groupStart   <= 1'b0;
      bufRdPointer <= '0;
      cntGrp       <= '0;
    end else begin
      bufGetWord <= tick;
      frameStart <= tick && (bufRdPointer == '0);
      groupStart <= tick && (bufRdPointer == '0) && (cntGrp == '0);
      if (bufGetWord) begin
        if (state_d == IDLE) begin
          bufRdPointer <= '0;
          cntGrp       <= '0;
        end else if (bufRdPointer == PTR_LAST) begin
          bufRdPointer <= '0;
          cntGrp       <= (cntGrp == GRP_LAST) ? '0 : cntGrp + GRP_W'(1);
        end else begin
          bufRdPointer <= bufRdPointer + PTR_W'(1);
        end
      end
    end
  end

  assign running = (state != IDLE);

endmodule
